// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if
//   Render-command stream between the command FIFO and the sprite blitter.
//   cmd_valid : producer has a command word on cmd_data
//   cmd_ready : consumer takes the word on this clock edge
//   cmd_data  : [47:40] magic, [39:24] x, [23:8] y, [7:0] flags
//               (a clear command carries its colour in [23:0])
//   master = command producer, slave = blitter.
interface sprite_blitter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_data;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Double-buffered sprite renderer. Pops render commands, looks up sprite
//   geometry in a runtime-writable descriptor table and copies sprite ROM
//   pixels into the back framebuffer with clipping, colour-key transparency
//   and horizontal flip. Also fills the back buffer with a solid colour and
//   swaps front/back buffers on the frame boundary.
// Ports
//   clk50, reset_n        : clock, asynchronous active-low reset
//   cmd (slave)           : render-command valid/ready stream
//   desc_we/idx/base/w/h  : descriptor table write port (any state)
//   rom_addr / rom_data   : sprite ROM, data one cycle after address
//   fb_we/sel/addr/din    : back-buffer write port, fb_sel = ~front_buf
//   frame_sync            : end-of-field pulse from the VGA timing
//   front_buf, frame_done : displayed buffer, one-cycle pulse on swap
//   busy, err_magic       : not in FETCH, pulse on dropped unknown magic
module sprite_blitter #(
    parameter int               H_RES     = 640,
    parameter int               V_RES     = 480,
    parameter int               PIX_W     = 24,
    parameter int               ROM_AW    = 17,
    parameter int               FB_AW     = 19,
    parameter int               N_SPRITES = 16,
    parameter int               DIM_W     = 10,
    parameter logic [PIX_W-1:0] KEY       = PIX_W'(24'hFF00FF)
) (
    input  logic                         clk50,
    input  logic                         reset_n,
    sprite_blitter_if.slave              cmd,
    input  logic                         desc_we,
    input  logic [$clog2(N_SPRITES)-1:0] desc_idx,
    input  logic [ROM_AW-1:0]            desc_base,
    input  logic [DIM_W-1:0]             desc_w,
    input  logic [DIM_W-1:0]             desc_h,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [PIX_W-1:0]             rom_data,
    output logic                         fb_we,
    output logic                         fb_sel,
    output logic [FB_AW-1:0]             fb_addr,
    output logic [PIX_W-1:0]             fb_din,
    input  logic                         frame_sync,
    output logic                         front_buf,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         err_magic
);

    localparam int                IDX_W       = $clog2(N_SPRITES);
    localparam logic signed [16:0] H_LIM      = 17'(H_RES);
    localparam logic signed [16:0] V_LIM      = 17'(V_RES);
    localparam logic [FB_AW-1:0]  FB_LAST     = FB_AW'(H_RES * V_RES - 1);
    localparam logic [7:0]        MAGIC_SWAP  = 8'hFF;
    localparam logic [7:0]        MAGIC_CLEAR = 8'hFE;

    typedef enum logic [2:0] {FETCH, SETUP, DRAW, DRAIN, CLEAR, WAIT_SYNC} state_t;

    typedef struct packed {
        logic [ROM_AW-1:0] base;
        logic [DIM_W-1:0]  w;
        logic [DIM_W-1:0]  h;
    } desc_t;

    state_t state_q, state_d;

    // Command fields
    logic [7:0]  magic;
    logic [15:0] cmd_x, cmd_y;
    assign magic = cmd.cmd_data[47:40];
    assign cmd_x = cmd.cmd_data[39:24];
    assign cmd_y = cmd.cmd_data[23:8];

    // Descriptor table
    desc_t desc_tbl [N_SPRITES];
    desc_t desc_sel;

    // Latched command / sprite context
    logic               run_q;
    logic [IDX_W-1:0]   idx_q;
    logic [15:0]        x_q, y_q;
    logic               flip_q;
    logic [PIX_W-1:0]   colour_q;
    logic [ROM_AW-1:0]  src_row_q;
    logic [DIM_W-1:0]   w_q, h_q, cx_q, cy_q;
    logic signed [16:0] x0_q, y0_q;
    logic [FB_AW-1:0]   clear_cnt_q;
    logic               drain_q;

    // Pixel pipeline
    logic               p1_ok_q;
    logic [FB_AW-1:0]   p1_addr_q;
    logic               fb_we_q;
    logic [FB_AW-1:0]   fb_addr_q;
    logic [PIX_W-1:0]   fb_din_q;

    // Control decoded from state
    logic fire, bad_magic, draw_act, clear_act, ready_c, busy_c;
    logic cx_last, draw_last;

    // NOTE: the descriptor table is a handful of registers, so it is reset
    // with everything else; a RAM-backed table could not be cleared this way.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SPRITES; i++) desc_tbl[i] <= '0;
        end else if (desc_we) begin
            desc_tbl[desc_idx] <= '{base: desc_base, w: desc_w, h: desc_h};
        end
    end

    assign desc_sel = desc_tbl[idx_q];

    // NOTE: sequential logic uses non-blocking assignments so every register
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;   // holds cmd_ready low until the first edge after release
        end
    end

    assign cx_last   = (cx_q == w_q - DIM_W'(1));
    assign draw_last = cx_last && (cy_q == h_q - DIM_W'(1));

    // NOTE: every signal written here gets a default first, so no latches.
    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b0;
        busy_c    = 1'b1;
        fire      = 1'b0;
        bad_magic = 1'b0;
        draw_act  = 1'b0;
        clear_act = 1'b0;
        unique case (state_q)
            FETCH: begin
                busy_c  = 1'b0;
                ready_c = run_q;
                fire    = cmd.cmd_valid && run_q;
                if (fire) begin
                    if (magic == MAGIC_SWAP)            state_d = WAIT_SYNC;
                    else if (magic == MAGIC_CLEAR)      state_d = CLEAR;
                    else if (32'(magic) < N_SPRITES)    state_d = SETUP;
                    else                                bad_magic = 1'b1;
                end
            end
            SETUP:     state_d = (desc_sel.w == '0 || desc_sel.h == '0) ? FETCH : DRAW;
            DRAW: begin
                draw_act = 1'b1;
                if (draw_last) state_d = DRAIN;
            end
            DRAIN:     if (drain_q) state_d = FETCH;
            CLEAR: begin
                clear_act = 1'b1;
                if (clear_cnt_q == FB_LAST) state_d = FETCH;
            end
            WAIT_SYNC: if (frame_sync) state_d = FETCH;
            default:   state_d = FETCH;
        endcase
    end

    assign cmd.cmd_ready = ready_c;
    assign busy          = busy_c;

    // Command latch, sprite setup and raster counters
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            flip_q      <= 1'b0;
            colour_q    <= '0;
            src_row_q   <= '0;
            w_q         <= '0;
            h_q         <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            clear_cnt_q <= '0;
            drain_q     <= 1'b0;
        end else begin
            case (state_q)
                FETCH: if (fire) begin
                    idx_q       <= magic[IDX_W-1:0];
                    x_q         <= cmd_x;
                    y_q         <= cmd_y;
                    flip_q      <= cmd.cmd_data[0];
                    colour_q    <= PIX_W'(cmd.cmd_data[23:0]);
                    clear_cnt_q <= '0;
                end
                SETUP: begin
                    // The descriptor is captured here; later table writes
                    // only affect later commands.
                    w_q       <= desc_sel.w;
                    h_q       <= desc_sel.h;
                    src_row_q <= desc_sel.base;
                    x0_q      <= {x_q[15], x_q} - 17'(desc_sel.w >> 1);
                    y0_q      <= {y_q[15], y_q} - 17'(desc_sel.h >> 1);
                    cx_q      <= '0;
                    cy_q      <= '0;
                end
                DRAW: begin
                    if (cx_last) begin
                        cx_q      <= '0;
                        cy_q      <= cy_q + DIM_W'(1);
                        src_row_q <= src_row_q + ROM_AW'(w_q);
                    end else begin
                        cx_q <= cx_q + DIM_W'(1);
                    end
                end
                DRAIN: drain_q     <= ~drain_q;
                CLEAR: clear_cnt_q <= clear_cnt_q + FB_AW'(1);
                default: ;
            endcase
        end
    end

    // Stage 0: source address and destination coordinates
    logic [DIM_W-1:0]   src_col;
    logic signed [16:0] px, py;
    logic               in_range;
    logic [FB_AW-1:0]   lin_addr;

    assign src_col  = flip_q ? (w_q - DIM_W'(1) - cx_q) : cx_q;
    assign rom_addr = draw_act ? (src_row_q + ROM_AW'(src_col)) : '0;
    assign px       = x0_q + 17'(cx_q);
    assign py       = y0_q + 17'(cy_q);
    // Clip first: the address is only formed from coordinates already known
    // to be on screen, so the 16-bit slices below are never negative.
    assign in_range = !px[16] && (px < H_LIM) && !py[16] && (py < V_LIM);
    assign lin_addr = FB_AW'(32'(py[15:0]) * 32'(H_RES) + 32'(px[15:0]));

    // Stage 1 holds the address while ROM data arrives; stage 2 applies the
    // colour key and drives the write port. Both clear asynchronously so a
    // reset mid-draw never lets a queued pixel land.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            p1_ok_q   <= 1'b0;
            p1_addr_q <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_din_q  <= '0;
        end else begin
            p1_ok_q   <= draw_act && in_range;
            p1_addr_q <= in_range ? lin_addr : '0;
            fb_we_q   <= p1_ok_q && (rom_data != KEY);
            fb_addr_q <= p1_addr_q;
            fb_din_q  <= rom_data;
        end
    end

    // Clear writes bypass the pixel pipeline (which is empty by then) so the
    // whole fill happens while the block is still in CLEAR.
    assign fb_we   = clear_act | fb_we_q;
    assign fb_addr = clear_act ? clear_cnt_q : fb_addr_q;
    assign fb_din  = clear_act ? colour_q    : fb_din_q;

    // Buffer swap and status pulses
    logic front_q, done_q, err_q;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            front_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= (state_q == WAIT_SYNC) && frame_sync;
            err_q  <= bad_magic;
            if ((state_q == WAIT_SYNC) && frame_sync) front_q <= ~front_q;
        end
    end

    assign front_buf  = front_q;
    assign fb_sel     = ~front_q;
    assign frame_done = done_q;
    assign err_magic  = err_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter
//   Drives two blitters: a 640x480 instance for sprite, swap and reset
//   sequences, and an 8x4 instance for the buffer clear. Expected writes are
//   queued when a command is issued and matched as the DUT writes them.
module tb_sprite_blitter;

    logic clk50   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk50 = ~clk50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk50) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shared stimulus
    logic        desc_we    = 1'b0;
    logic [3:0]  desc_idx   = '0;
    logic [16:0] desc_base  = '0;
    logic [9:0]  desc_w     = '0;
    logic [9:0]  desc_h     = '0;
    logic        frame_sync = 1'b0;
    logic        key106     = 1'b0;

    sprite_blitter_if big_if ();
    sprite_blitter_if sml_if ();

    // Large instance
    logic [16:0] b_rom_addr;
    logic [23:0] b_rom_data = '0;
    logic        b_fb_we, b_fb_sel, b_front, b_done, b_busy, b_err;
    logic [18:0] b_fb_addr;
    logic [23:0] b_fb_din;

    sprite_blitter u_big (
        .clk50      (clk50),
        .reset_n    (reset_n),
        .cmd        (big_if),
        .desc_we    (desc_we),
        .desc_idx   (desc_idx),
        .desc_base  (desc_base),
        .desc_w     (desc_w),
        .desc_h     (desc_h),
        .rom_addr   (b_rom_addr),
        .rom_data   (b_rom_data),
        .fb_we      (b_fb_we),
        .fb_sel     (b_fb_sel),
        .fb_addr    (b_fb_addr),
        .fb_din     (b_fb_din),
        .frame_sync (frame_sync),
        .front_buf  (b_front),
        .frame_done (b_done),
        .busy       (b_busy),
        .err_magic  (b_err)
    );

    // Small instance for the clear sequence
    logic [16:0] s_rom_addr;
    logic [23:0] s_rom_data = '0;
    logic        s_fb_we, s_fb_sel, s_front, s_done, s_busy, s_err;
    logic [18:0] s_fb_addr;
    logic [23:0] s_fb_din;

    sprite_blitter #(.H_RES(8), .V_RES(4)) u_sml (
        .clk50      (clk50),
        .reset_n    (reset_n),
        .cmd        (sml_if),
        .desc_we    (desc_we),
        .desc_idx   (desc_idx),
        .desc_base  (desc_base),
        .desc_w     (desc_w),
        .desc_h     (desc_h),
        .rom_addr   (s_rom_addr),
        .rom_data   (s_rom_data),
        .fb_we      (s_fb_we),
        .fb_sel     (s_fb_sel),
        .fb_addr    (s_fb_addr),
        .fb_din     (s_fb_din),
        .frame_sync (frame_sync),
        .front_buf  (s_front),
        .frame_done (s_done),
        .busy       (s_busy),
        .err_magic  (s_err)
    );

    // Sprite ROM: word = 0x300000 + address, optionally with word 106 keyed.
    function automatic logic [23:0] rom_word(input logic [16:0] a);
        if (key106 && a == 17'd106) return 24'hFF00FF;
        return 24'h300000 + 24'(a);
    endfunction

    always @(posedge clk50) b_rom_data <= rom_word(b_rom_addr);

    // Scoreboards and monitors
    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] din;
        logic        sel;
    } wr_t;

    wr_t         sb_b[$];
    wr_t         sb_s[$];
    logic [16:0] rom_log[$];
    wr_t         e_b, e_s;
    int          first_rom_cyc = -1;
    int          first_we_cyc  = -1;
    int          done_cnt = 0, err_cnt = 0;
    int          s_wr_cnt = 0, s_first = -1, s_last = -1;

    always @(negedge clk50) begin
        if (reset_n) begin
            if (b_busy && b_rom_addr != '0) begin
                rom_log.push_back(b_rom_addr);
                if (first_rom_cyc < 0) first_rom_cyc = cyc;
            end
            if (b_done) done_cnt++;
            if (b_err)  err_cnt++;
            if (b_fb_we) begin
                if (first_we_cyc < 0) first_we_cyc = cyc;
                check("unexpected_write", 64'(sb_b.size() == 0), 64'(0));
                if (sb_b.size() != 0) begin
                    e_b = sb_b.pop_front();
                    check("wr_addr", 64'(b_fb_addr), 64'(e_b.addr));
                    check("wr_din",  64'(b_fb_din),  64'(e_b.din));
                    check("wr_sel",  64'(b_fb_sel),  64'(e_b.sel));
                end
            end
            if (s_fb_we) begin
                s_wr_cnt++;
                if (s_first < 0) s_first = cyc;
                s_last = cyc;
                check("clear_ready_low", 64'(sml_if.cmd_ready), 64'(0));
                check("clear_unexpected", 64'(sb_s.size() == 0), 64'(0));
                if (sb_s.size() != 0) begin
                    e_s = sb_s.pop_front();
                    check("clear_addr", 64'(s_fb_addr), 64'(e_s.addr));
                    check("clear_din",  64'(s_fb_din),  64'(e_s.din));
                end
            end
        end
    end

    // Drivers
    task automatic write_desc(input logic [3:0] idx, input logic [16:0] base,
                              input logic [9:0] w, input logic [9:0] h);
        @(posedge clk50); #1;
        desc_we = 1'b1; desc_idx = idx; desc_base = base; desc_w = w; desc_h = h;
        @(posedge clk50); #1;
        desc_we = 1'b0;
    endtask

    task automatic send_big(input logic [47:0] d);
        int n = 0;
        big_if.cmd_valid = 1'b1;
        big_if.cmd_data  = d;
        while (!big_if.cmd_ready && n < 100) begin @(posedge clk50); #1; n++; end
        check("big_cmd_accept", 64'(big_if.cmd_ready), 64'(1));
        @(posedge clk50); #1;
        big_if.cmd_valid = 1'b0;
    endtask

    task automatic send_sml(input logic [47:0] d);
        int n = 0;
        sml_if.cmd_valid = 1'b1;
        sml_if.cmd_data  = d;
        while (!sml_if.cmd_ready && n < 100) begin @(posedge clk50); #1; n++; end
        check("sml_cmd_accept", 64'(sml_if.cmd_ready), 64'(1));
        @(posedge clk50); #1;
        sml_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle_big();
        int n = 0;
        while (b_busy && n < 2000) begin @(posedge clk50); #1; n++; end
        check("big_idle_in_time", 64'(b_busy), 64'(0));
        repeat (3) @(posedge clk50);
        #1;
    endtask

    task automatic push_sprite(input logic [16:0] base, input logic flip, input logic sel);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                sb_b.push_back(wr_t'{addr: 19'(12168 + 640 * r + c),
                                     din:  rom_word(17'(base + 4 * r + (flip ? 3 - c : c))),
                                     sel:  sel});
    endtask

    // Vector table
    typedef struct packed {
        logic [7:0]        magic;
        logic [15:0]       x;
        logic [15:0]       y;
        logic [7:0]        flags;
        logic              key;
        logic [3:0]        n;
        logic              err;
        logic [7:0][18:0]  addr;
        logic [7:0][16:0]  rom;
    } vec_t;

    localparam int N_VEC = 6;
    vec_t vecs[N_VEC];

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        big_if.cmd_valid = 1'b0;
        big_if.cmd_data  = '0;
        sml_if.cmd_valid = 1'b0;
        sml_if.cmd_data  = '0;

        // Basic draw, desc 2 = {100,4,2} at (10,20): top-left (8,19)
        vecs[0] = '0;
        vecs[0].magic = 8'd2; vecs[0].x = 16'd10; vecs[0].y = 16'd20; vecs[0].n = 4'd8;
        for (int k = 0; k < 4; k++) begin
            vecs[0].addr[k]     = 19'(12168 + k);
            vecs[0].addr[k + 4] = 19'(12808 + k);
            vecs[0].rom[k]      = 17'(100 + k);
            vecs[0].rom[k + 4]  = 17'(104 + k);
        end
        // Flipped: each row reads its source right to left
        vecs[1] = vecs[0];
        vecs[1].flags = 8'd1;
        for (int k = 0; k < 4; k++) begin
            vecs[1].rom[k]     = 17'(103 - k);
            vecs[1].rom[k + 4] = 17'(107 - k);
        end
        // Clip and key at (1,1): top-left (-1,0), column -1 clipped, word 106 keyed
        vecs[2] = '0;
        vecs[2].magic = 8'd2; vecs[2].x = 16'd1; vecs[2].y = 16'd1; vecs[2].key = 1'b1;
        vecs[2].n = 4'd5;
        vecs[2].addr[0] = 19'd0;   vecs[2].rom[0] = 17'd101;
        vecs[2].addr[1] = 19'd1;   vecs[2].rom[1] = 17'd102;
        vecs[2].addr[2] = 19'd2;   vecs[2].rom[2] = 17'd103;
        vecs[2].addr[3] = 19'd640; vecs[2].rom[3] = 17'd105;
        vecs[2].addr[4] = 19'd642; vecs[2].rom[4] = 17'd107;
        // Unknown magic is dropped with an error pulse
        vecs[3] = '0; vecs[3].magic = 8'h20; vecs[3].err = 1'b1;
        // Never-written descriptor (reset to zero size): no writes
        vecs[4] = '0; vecs[4].magic = 8'd5;
        // Zero-width descriptor: no writes
        vecs[5] = '0; vecs[5].magic = 8'd3; vecs[5].x = 16'd30; vecs[5].y = 16'd30;

        // Reset state
        repeat (3) @(posedge clk50);
        #1;
        check("rst_cmd_ready", 64'(big_if.cmd_ready), 64'(0));
        check("rst_busy",      64'(b_busy),           64'(0));
        check("rst_fb_we",     64'(b_fb_we),          64'(0));
        check("rst_front_buf", 64'(b_front),          64'(0));
        check("rst_fb_sel",    64'(b_fb_sel),         64'(1));
        check("rst_rom_addr",  64'(b_rom_addr),       64'(0));
        check("rst_sml_fb_we", 64'(s_fb_we),          64'(0));
        check("rst_sml_err",   64'(s_err | s_done),   64'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clk50);
        #1;
        check("ready_after_release", 64'(big_if.cmd_ready), 64'(1));

        write_desc(4'd2, 17'd100, 10'd4, 10'd2);
        write_desc(4'd3, 17'd50,  10'd0, 10'd5);

        for (int v = 0; v < N_VEC; v++) begin
            int e0;
            e0     = err_cnt;
            key106 = vecs[v].key;
            rom_log.delete();
            first_rom_cyc = -1;
            first_we_cyc  = -1;
            for (int k = 0; k < int'(vecs[v].n); k++)
                sb_b.push_back(wr_t'{addr: vecs[v].addr[k], din: rom_word(vecs[v].rom[k]), sel: 1'b1});
            send_big({vecs[v].magic, vecs[v].x, vecs[v].y, vecs[v].flags});
            if (vecs[v].err) check("ready_after_err", 64'(big_if.cmd_ready), 64'(1));
            wait_idle_big();
            check("err_pulses", 64'(err_cnt - e0), 64'(vecs[v].err));
            check("vec_writes_done", 64'(sb_b.size()), 64'(0));
            if (v == 0) begin
                check("rom_addr_count", 64'(rom_log.size()), 64'(8));
                for (int i = 0; i < rom_log.size() && i < 8; i++)
                    check("rom_addr_seq", 64'(rom_log[i]), 64'(100 + i));
                check("rom_to_we_latency", 64'(first_we_cyc - first_rom_cyc), 64'(2));
            end
        end
        key106 = 1'b0;

        // Clear on the 8x4 instance
        for (int i = 0; i < 32; i++)
            sb_s.push_back(wr_t'{addr: 19'(i), din: 24'h123456, sel: 1'b1});
        send_sml({8'hFE, 16'h0, 24'h123456});
        for (int n = 0; n < 200 && s_busy; n++) begin @(posedge clk50); #1; end
        check("clear_idle_in_time", 64'(s_busy), 64'(0));
        repeat (2) @(posedge clk50);
        #1;
        check("clear_count",   64'(s_wr_cnt), 64'(32));
        check("clear_span",    64'(s_last - s_first + 1), 64'(32));
        check("clear_drained", 64'(sb_s.size()), 64'(0));

        // Frame swap: 0xFF then frame_sync 50 cycles later
        send_big({8'hFF, 40'h0});
        repeat (49) @(posedge clk50);
        #1;
        check("swap_waiting_busy",  64'(b_busy),   64'(1));
        check("swap_waiting_front", 64'(b_front),  64'(0));
        check("swap_no_early_done", 64'(done_cnt), 64'(0));
        frame_sync = 1'b1;
        @(posedge clk50); #1;
        frame_sync = 1'b0;
        check("swap_front_buf",  64'(b_front),  64'(1));
        check("swap_frame_done", 64'(b_done),   64'(1));
        check("swap_fb_sel",     64'(b_fb_sel), 64'(0));
        @(posedge clk50); #1;
        check("swap_done_one_cycle", 64'(b_done), 64'(0));
        check("swap_back_to_fetch",  64'(b_busy), 64'(0));

        // Draw into the other buffer; frame_sync and a descriptor rewrite
        // during DRAW must not disturb the running command
        push_sprite(17'd100, 1'b0, 1'b0);
        send_big({8'd2, 16'd10, 16'd20, 8'd0});
        repeat (2) @(posedge clk50);
        #1;
        frame_sync = 1'b1;
        desc_we = 1'b1; desc_idx = 4'd2; desc_base = 17'd200; desc_w = 10'd4; desc_h = 10'd2;
        @(posedge clk50); #1;
        frame_sync = 1'b0;
        desc_we    = 1'b0;
        wait_idle_big();
        check("sync_in_draw_front", 64'(b_front),     64'(1));
        check("sync_in_draw_done",  64'(done_cnt),    64'(1));
        check("sync_in_draw_wrs",   64'(sb_b.size()), 64'(0));

        // The rewritten descriptor applies to the next command
        push_sprite(17'd200, 1'b0, 1'b0);
        send_big({8'd2, 16'd10, 16'd20, 8'd0});
        wait_idle_big();
        check("new_desc_wrs", 64'(sb_b.size()), 64'(0));

        // Reset in the middle of a draw
        push_sprite(17'd200, 1'b0, 1'b0);
        send_big({8'd2, 16'd10, 16'd20, 8'd0});
        repeat (5) @(posedge clk50);
        #1;
        check("we_before_reset", 64'(b_fb_we), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_fb_we_async", 64'(b_fb_we),          64'(0));
        check("reset_front_buf",   64'(b_front),          64'(0));
        check("reset_busy",        64'(b_busy),           64'(0));
        check("reset_cmd_ready",   64'(big_if.cmd_ready), 64'(0));
        sb_b.delete();
        repeat (3) @(posedge clk50);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk50);
        #1;
        check("post_reset_ready", 64'(big_if.cmd_ready), 64'(1));
        check("post_reset_no_we", 64'(b_fb_we),          64'(0));

        // Descriptor table was cleared: sprite 2 is now zero-sized
        send_big({8'd2, 16'd10, 16'd20, 8'd0});
        wait_idle_big();
        check("cleared_desc_no_writes", 64'(sb_b.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
